// File: rtl/bram_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module : bram_stream_reader_pkg
// Brief  : shared FSM encoding and default widths for the BRAM stream reader
// Rev    : 1.0
// ============================================================================
package bram_stream_reader_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int RAM_DEPTH  = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rd_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module : rd_skid_fifo
// Brief  : 2-entry FIFO (data + last flag) catching BRAM read returns
// Rev    : 1.0
// ============================================================================
module rd_skid_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] r_data0;
  logic [DATA_W-1:0] r_data1;
  logic              r_last0;
  logic              r_last1;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_push;
  logic              w_pop;

  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data0  <= '0;
      r_data1  <= '0;
      r_last0  <= 1'b0;
      r_last1  <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (clear) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        if (r_wr_ptr) begin
          r_data1 <= push_data;
          r_last1 <= push_last;
        end else begin
          r_data0 <= push_data;
          r_last0 <= push_last;
        end
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The head slot is only overwritten after it has been popped, so it holds steady.
  assign head_data = r_rd_ptr ? r_data1 : r_data0;
  assign head_last = r_rd_ptr ? r_last1 : r_last0;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module : bram_stream_reader
// Brief  : reads a wrapping BRAM address range and emits it as a valid/ready stream
// Rev    : 1.0
// ============================================================================
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic              ram_reset,
  output logic [ADDR_W-1:0] ram_ad,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam logic [ADDR_W:0]   c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_issued;
  logic [ADDR_W:0]   r_accepted;
  logic              r_in_flight;
  logic              r_in_flight_last;
  logic [1:0]        w_count;
  logic [2:0]        w_credit;
  logic              w_pop;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_last_pop;
  logic              w_clear;

  assign w_pop        = m_valid && m_ready;
  // Slots that will be occupied after this edge if nothing new is issued.
  assign w_credit     = {1'b0, w_count} + {2'b00, r_in_flight} - {2'b00, w_pop};
  assign w_issue_last = (r_issued + c_cnt_one) == r_len;
  assign w_last_pop   = w_pop && ((r_accepted + c_cnt_one) == r_len);
  assign w_clear      = abort && (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    busy        = (r_state != ST_IDLE);
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (length == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if ((r_issued != r_len) && (w_credit < 3'd2)) begin
          w_issue = 1'b1;
          if (w_issue_last) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last_pop && !r_in_flight) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = !abort;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr           <= '0;
      r_len            <= '0;
      r_issued         <= '0;
      r_accepted       <= '0;
      r_in_flight      <= 1'b0;
      r_in_flight_last <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (start) begin
          r_addr     <= base_addr;
          r_len      <= length;
          r_issued   <= '0;
          r_accepted <= '0;
        end
      end else begin
        if (w_issue) begin
          r_addr   <= r_addr + c_addr_one;
          r_issued <= r_issued + c_cnt_one;
        end
        if (w_pop) begin
          r_accepted <= r_accepted + c_cnt_one;
        end
      end
      // Abort suppresses w_issue, so the outstanding read is forgotten here too.
      r_in_flight      <= w_issue;
      r_in_flight_last <= w_issue && w_issue_last;
    end
  end

  rd_skid_fifo #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_clear),
    .push      (r_in_flight),
    .push_data (ram_dout),
    .push_last (r_in_flight_last),
    .pop       (w_pop),
    .head_data (m_data),
    .head_last (m_last),
    .count     (w_count)
  );

  assign m_valid   = (w_count != 2'd0);
  assign ram_ce    = w_issue;
  assign ram_ad    = r_addr;
  assign ram_oce   = 1'b1;
  assign ram_wre   = 1'b0;
  assign ram_reset = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_bram_stream_reader
// Brief  : self-checking bench with a RAM model and a queue-based stream scoreboard
// Rev    : 1.0
// ============================================================================
module tb_bram_stream_reader;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       start     = 1'b0;
  logic       abort     = 1'b0;
  logic       m_ready   = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] length    = '0;
  logic [7:0] ram_dout  = '0;
  logic       busy, done, ram_ce, ram_oce, ram_wre, ram_reset, m_valid, m_last;
  logic [7:0] ram_ad, m_data;
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_ce) ram_dout <= mem[ram_ad];

  bram_stream_reader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .busy(busy), .done(done), .ram_ce(ram_ce), .ram_oce(ram_oce),
    .ram_wre(ram_wre), .ram_reset(ram_reset), .ram_ad(ram_ad), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [8:0] exp_q[$];
  logic [7:0] exp_addr_q[$];
  int         n_out;
  logic       done_due, exp_busy, hold_valid, hold_last;
  logic [7:0] hold_data;
  int         obs_first_cyc, obs_done_cyc, obs_nwords;
  logic [7:0] obs_first_data, obs_last_data;

  typedef struct {
    logic [7:0] base;
    int         len;
    int         first_cyc;
    logic [7:0] first_data;
    logic [7:0] last_data;
    int         done_cyc;
    int         nwords;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_addr_q.delete();
    n_out      = 0;
    done_due   = 1'b0;
    exp_busy   = 1'b0;
    hold_valid = 1'b0;
  endtask

  // Sampled at the falling edge, between input changes and the next active edge.
  task automatic monitor();
    logic [8:0] pkt;
    logic [7:0] ea;
    chk("ram_oce", 32'(ram_oce), 32'd1);
    chk("ram_wre", 32'(ram_wre), 32'd0);
    chk("ram_reset", 32'(ram_reset), 32'd0);
    chk("done", 32'(done), 32'(done_due));
    chk("busy", 32'(busy), 32'(exp_busy));
    if (done_due) begin
      obs_done_cyc = cyc;
      exp_busy     = 1'b0;
      done_due     = 1'b0;
    end
    if (ram_ce) begin
      if (exp_addr_q.size() == 0) begin
        fail("ram_ce_unexpected", "ram_ce=1, required 0");
      end else begin
        ea = exp_addr_q.pop_front();
        chk("ram_ad", 32'(ram_ad), 32'(ea));
      end
      n_out++;
    end
    chk("spurious_valid", 32'(m_valid && (exp_q.size() == 0)), 32'd0);
    if (hold_valid) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(hold_data));
      chk("hold_last", 32'(m_last), 32'(hold_last));
    end
    if (m_valid && (obs_first_cyc < 0)) begin
      obs_first_cyc  = cyc;
      obs_first_data = m_data;
    end
    if (m_valid && m_ready && (exp_q.size() != 0)) begin
      pkt = exp_q.pop_front();
      chk("m_data", 32'(m_data), 32'(pkt[7:0]));
      chk("m_last", 32'(m_last), 32'(pkt[8]));
      n_out--;
      obs_nwords++;
      obs_last_data = m_data;
      if (exp_q.size() == 0) done_due = 1'b1;
    end
    checks++;
    if (n_out > 2) begin
      errors++;
      $display("FAIL buffered_words: got %0d, required <= 2 (cycle %0d)", n_out, cyc);
    end
    hold_valid = m_valid && !m_ready;
    hold_data  = m_data;
    hold_last  = m_last;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    start   = 1'b0;
    m_ready = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  function automatic logic ready_val(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ram_ce"}, 32'(ram_ce), 32'd0);
    chk({tag, "_ram_ad"}, 32'(ram_ad), 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    chk({tag, "_m_last"}, 32'(m_last), 32'd0);
    chk({tag, "_ram_oce"}, 32'(ram_oce), 32'd1);
    chk({tag, "_ram_wre"}, 32'(ram_wre), 32'd0);
    chk({tag, "_ram_reset"}, 32'(ram_reset), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Expected stream: word k comes from address (base + k) mod 256, last on k = len-1.
  task automatic begin_txn(input logic [7:0] b, input int len);
    clear_model();
    for (int k = 0; k < len; k++) begin
      exp_addr_q.push_back(b + 8'(k));
      exp_q.push_back({(k == len - 1), mem[b + 8'(k)]});
    end
    obs_first_cyc  = -1;
    obs_done_cyc   = -1;
    obs_nwords     = 0;
    obs_first_data = '0;
    obs_last_data  = '0;
    cyc            = 0;
    start          = 1'b1;
    base_addr      = b;
    length         = 9'(len);
    step();
    start    = 1'b0;
    exp_busy = 1'b1;
    if (len == 0) done_due = 1'b1;
  endtask

  task automatic run_txn(input logic [7:0] b, input int len, input int mode);
    int budget;
    budget  = 4 * len + 20;
    m_ready = ready_val(mode);
    begin_txn(b, len);
    while ((obs_done_cyc < 0) && (cyc < budget)) begin
      m_ready = ready_val(mode);
      step();
    end
    if (obs_done_cyc < 0) begin
      fail("timeout", $sformatf("no done within %0d cycles for len %0d, required a pulse", budget, len));
      do_reset();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required summary before limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         len;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    clear_model();
    tv[0] = '{8'h10, 4, 3, 8'h4A, 8'h49, 7, 4};
    tv[1] = '{8'hFE, 4, 3, 8'hA4, 8'h5B, 7, 4};
    tv[2] = '{8'h00, 1, 3, 8'h5A, 8'h5A, 4, 1};
    tv[3] = '{8'h80, 2, 3, 8'hDA, 8'hDB, 5, 2};
    tv[4] = '{8'h33, 0, -1, 8'h00, 8'h00, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    for (int i = 0; i < 5; i++) begin
      run_txn(tv[i].base, tv[i].len, 0);
      chk("tbl_first_cyc", 32'(obs_first_cyc), 32'(tv[i].first_cyc));
      chk("tbl_first_data", 32'(obs_first_data), 32'(tv[i].first_data));
      chk("tbl_last_data", 32'(obs_last_data), 32'(tv[i].last_data));
      chk("tbl_done_cyc", 32'(obs_done_cyc), 32'(tv[i].done_cyc));
      chk("tbl_nwords", 32'(obs_nwords), 32'(tv[i].nwords));
      idle(2);
    end

    run_txn(8'h40, 8, 1);
    chk("bp_nwords", 32'(obs_nwords), 32'd8);
    idle(2);

    run_txn(8'h37, 256, 0);
    chk("len256_nwords", 32'(obs_nwords), 32'd256);
    chk("len256_done_cyc", 32'(obs_done_cyc), 32'd259);
    idle(2);

    // Abort partway through a 10-word read, then confirm a normal restart.
    m_ready = 1'b1;
    begin_txn(8'h20, 10);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    clear_model();
    idle(6);
    run_txn(8'h21, 3, 0);
    chk("post_abort_nwords", 32'(obs_nwords), 32'd3);
    chk("post_abort_done_cyc", 32'(obs_done_cyc), 32'd6);
    idle(2);

    // Two words buffered with no reads left, then an asynchronous reset.
    m_ready = 1'b0;
    begin_txn(8'h70, 2);
    start     = 1'b1;
    base_addr = 8'h99;
    length    = 9'd5;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_reset_valid", 32'(m_valid), 32'd1);
    chk("pre_reset_data", 32'(m_data), 32'(mem[8'h70]));
    chk("pre_reset_last", 32'(m_last), 32'd0);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    run_txn(8'h05, 5, 2);
    chk("post_reset_nwords", 32'(obs_nwords), 32'd5);
    idle(2);

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 40; t++) begin
      b   = 8'($urandom);
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(64, 256)) : int'($urandom_range(0, 12));
      run_txn(b, len, 2);
      chk("rnd_nwords", 32'(obs_nwords), 32'(len));
      idle(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_stream_reader.md
# bram_stream_reader

- Read-side client for the 256x8 dual-port block RAM used by the tracker's line/window buffers.
- Drives one RAM port (address, chip enable, output enable, write enable, reset), not the RAM itself.
- On a start pulse it reads a contiguous, wrapping address range and presents the bytes as a valid/ready stream.
- A 2-entry skid buffer absorbs the RAM's one-cycle read latency under back-pressure, so no read is lost and none is issued twice.

## Interface
- ADDR_W, 8, RAM address width (256 words)
- DATA_W, 8, RAM/stream data width
- clk  in  1  single clock for RAM port and stream
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first address, latched on accepted start
- length  in  ADDR_W+1  words to read, 0..256, latched on accepted start
- abort  in  1  synchronous flush; returns to IDLE, no done
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last word has been accepted downstream
- ram_ce  out  1  read strobe to RAM port
- ram_oce  out  1  constant 1 (RAM in bypass read mode)
- ram_wre  out  1  constant 0 (port is read-only)
- ram_reset  out  1  constant 0
- ram_ad  out  ADDR_W  RAM read address
- ram_dout  in  DATA_W  RAM read data, valid the cycle after ram_ce
- m_valid  out  1  stream word available
- m_ready  in  1  downstream accepts when high with m_valid
- m_data  out  DATA_W  stream word
- m_last  out  1  high with the final word of the range

## Operation
- **States:** IDLE, READ, DRAIN, DONE.
- **IDLE:**
  - start=1 and length≠0: latch base/length, go to READ.
  - start=1 and length=0: go to DONE (done pulses, no RAM access, no stream word).
- **READ:**
  - Assert ram_ce with ram_ad=next address when count + in_flight − pop < 2, where count is skid occupancy (0..2), in_flight is the read issued last cycle (0/1), and pop is m_valid&&m_ready.
  - Address increments mod 256; 255 wraps to 0.
  - After issuing length reads, go to DRAIN.
- **Data path:** ram_dout is pushed into the skid on the cycle after each ram_ce. Push and pop in the same cycle are allowed.
- **DRAIN:** when count=0, in_flight=0 and the last pop has occurred, go to DONE.
- **DONE:** done=1 for one cycle, then IDLE.
- **m_last:** high exactly when the head of the skid is word number length−1.
- **start while busy:** ignored, with no effect on latched values.
- **abort (any non-IDLE state):**
  - Next state IDLE, skid cleared, in_flight dropped.
  - ram_ce=0 from the following cycle; done is not pulsed.
  - abort and start in the same IDLE cycle: start wins.
- **Stream rule:** once m_valid is high, m_data/m_last hold until accepted (no retraction except on abort or rst_n).
- **Counters:** issued and accepted counters are ADDR_W+1 bits wide so length 256 does not overflow.

## Timing
- **Reset values:** busy=0, done=0, ram_ce=0, ram_ad=0, m_valid=0, m_data=0, m_last=0; ram_oce=1, ram_wre=0 and ram_reset=0 at all times. State IDLE, skid empty.
- **Latency:** start sampled at edge 0 → ram_ce=1, ram_ad=base in cycle 1 → ram_dout valid in cycle 2 → m_valid=1 in cycle 3.
- **Throughput:** with m_ready held high, one word per cycle, i.e. length words in cycles 3..length+2.
- **Completion:** done pulses the cycle after the last-word handshake; busy falls with done.
- **Back-pressure:** at most 2 words are buffered and 0 reads are issued while the skid is full with no pop.
- **Async reset:** rst_n low mid-operation clears everything immediately. RAM data returning after reset is discarded.

## Structure
- **Shared package:** state enum (IDLE/READ/DRAIN/DONE), ADDR_W/DATA_W defaults, RAM_DEPTH=256.
- **Sub-module:** rd_skid_fifo, a 2-entry FIFO with push/pop/count/clear, data+last payload, and async active-low reset.
- **Top level:** FSM, address/issue/accept counters, credit logic.

## Test plan
- **Basic read:** RAM preloaded addr i = i^8'h5A; start base=0x10 length=4, m_ready=1 → m_data 0x4A,0x4B,0x48,0x49 in cycles 3..6; m_last on 0x49; done in cycle 7.
- **Wrap:** base=0xFE length=4 → ram_ad sequence FE,FF,00,01; stream order matches.
- **Back-pressure:** length=8, m_ready toggles 1,0,0,1… → all 8 words in order, none duplicated; ram_ce never asserted while count=2 with no pop.
- **Boundaries:**
  - length=0 → done one cycle after start, no ram_ce, no m_valid.
  - length=256 → 256 words, m_last only on the last.
- **Abort:** abort in cycle 5 of a length=10 read → m_valid=0 and busy=0 next cycle, done never pulses; a fresh start then works normally.
- **Async reset:** rst_n low during DRAIN with 2 words buffered → all outputs at reset values immediately; start ignored while busy.
